// File: rtl/metroid_pkg.sv
// Shared types, defaults and the strobe decode for the frame-buffer SRAM arbiter.
package metroid_pkg;
  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_WR      = 3'd3,
    ST_TURN    = 3'd4
  } arb_state_t;

  // Active-low strobes {ce_n, oe_n, we_n, ub_n, lb_n} for the cycle spent in state s.
  function automatic logic [4:0] sram_ctrl(input arb_state_t s, input logic [1:0] be);
    logic [4:0] v;
    case (s)
      ST_RD_ADDR, ST_RD_CAP: v = 5'b00100;
      ST_WR:                 v = {3'b010, ~be[1], ~be[0]};
      default:               v = 5'b11111;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/sram_io_reg.sv
// Registered SRAM pins, grant/rvalid strobes, read-data capture and the DQ tri-state driver.
module sram_io_reg
  import metroid_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              vgaClk,
  input  logic              reset,
  input  arb_state_t        i_nxt_state,
  input  logic              i_grant_drw,
  input  logic              i_grant_blt,
  input  logic              i_cap_drw,
  input  logic              i_cap_blt,
  input  logic [ADDR_W-1:0] i_drw_addr,
  input  logic [ADDR_W-1:0] i_blt_addr,
  input  logic [DATA_W-1:0] i_blt_wdata,
  input  logic [1:0]        i_blt_be,
  output logic              o_drw_grant,
  output logic              o_blt_grant,
  output logic              o_drw_rvalid,
  output logic              o_blt_rvalid,
  output logic [DATA_W-1:0] o_drw_rdata,
  output logic [DATA_W-1:0] o_blt_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
);
  logic              r_drw_grant, r_blt_grant, r_drw_rvalid, r_blt_rvalid, r_dq_oe;
  logic [DATA_W-1:0] r_drw_rdata, r_blt_rdata, r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_ctrl;
  logic [4:0]        w_ctrl_nxt;

  // Strobes follow the state being entered, so they line up with that state's cycle.
  assign w_ctrl_nxt = sram_ctrl(i_nxt_state, i_blt_be);

  // Output register bank; DQ is sampled on the edge that ends RD_CAP.
  always_ff @(posedge vgaClk) begin
    if (!reset) begin
      r_drw_grant  <= 1'b0;
      r_blt_grant  <= 1'b0;
      r_drw_rvalid <= 1'b0;
      r_blt_rvalid <= 1'b0;
      r_dq_oe      <= 1'b0;
      r_drw_rdata  <= '0;
      r_blt_rdata  <= '0;
      r_wdata      <= '0;
      r_addr       <= '0;
      r_ctrl       <= 5'b11111;
    end else begin
      r_drw_grant  <= i_grant_drw;
      r_blt_grant  <= i_grant_blt;
      r_drw_rvalid <= i_cap_drw;
      r_blt_rvalid <= i_cap_blt;
      r_dq_oe      <= (i_nxt_state == ST_WR);
      r_ctrl       <= w_ctrl_nxt;
      if (i_grant_drw) begin
        r_addr <= i_drw_addr;
      end else if (i_grant_blt) begin
        r_addr <= i_blt_addr;
      end
      if (i_grant_blt) begin
        r_wdata <= i_blt_wdata;
      end
      if (i_cap_drw) begin
        r_drw_rdata <= io_sram_dq;
      end
      if (i_cap_blt) begin
        r_blt_rdata <= io_sram_dq;
      end
    end
  end

  assign io_sram_dq   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
  assign o_drw_grant  = r_drw_grant;
  assign o_blt_grant  = r_blt_grant;
  assign o_drw_rvalid = r_drw_rvalid;
  assign o_blt_rvalid = r_blt_rvalid;
  assign o_drw_rdata  = r_drw_rdata;
  assign o_blt_rdata  = r_blt_rdata;
  assign o_sram_addr  = r_addr;
  assign {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n} = r_ctrl;
endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: drawer reads have priority, the blitter is guaranteed a slot
// after STARVE_MAX consecutive drawer grants.
module sram_arbiter
  import metroid_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              vgaClk,
  input  logic              reset,
  input  logic              drw_req,
  input  logic [ADDR_W-1:0] drw_addr,
  output logic              drw_grant,
  output logic [DATA_W-1:0] drw_rdata,
  output logic              drw_rvalid,
  input  logic              blt_req,
  input  logic              blt_we,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [DATA_W-1:0] blt_wdata,
  input  logic [1:0]        blt_be,
  output logic              blt_grant,
  output logic [DATA_W-1:0] blt_rdata,
  output logic              blt_rvalid,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t r_state, w_nxt_state;
  logic [3:0] r_starve, w_nxt_starve;
  logic       r_owner_blt, w_nxt_owner_blt;
  logic       w_grant_drw, w_grant_blt, w_cap_drw, w_cap_blt, w_blt_wins;

  assign w_blt_wins = blt_req && ((r_starve >= STARVE_LIM) || !drw_req);

  // State, starvation counter and owner of the read currently in flight.
  always_ff @(posedge vgaClk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_starve    <= 4'd0;
      r_owner_blt <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_starve    <= w_nxt_starve;
      r_owner_blt <= w_nxt_owner_blt;
    end
  end

  // Next-state, arbitration (only in IDLE and RD_CAP) and capture selection.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_owner_blt = r_owner_blt;
    w_grant_drw     = 1'b0;
    w_grant_blt     = 1'b0;
    w_cap_drw       = 1'b0;
    w_cap_blt       = 1'b0;
    case (r_state)
      ST_IDLE, ST_RD_CAP: begin
        if (r_state == ST_RD_CAP) begin
          w_cap_drw = !r_owner_blt;
          w_cap_blt = r_owner_blt;
        end else begin
          w_cap_drw = 1'b0;
        end
        if (w_blt_wins) begin
          w_grant_blt     = 1'b1;
          w_nxt_owner_blt = 1'b1;
          w_nxt_state     = blt_we ? ST_WR : ST_RD_ADDR;
        end else if (drw_req) begin
          w_grant_drw     = 1'b1;
          w_nxt_owner_blt = 1'b0;
          w_nxt_state     = ST_RD_ADDR;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_RD_ADDR: w_nxt_state = ST_RD_CAP;
      ST_WR:      w_nxt_state = ST_TURN;
      ST_TURN:    w_nxt_state = ST_IDLE;
      default:    w_nxt_state = ST_IDLE;
    endcase
  end

  // Counter saturates so a stalled blitter can never wrap back below the limit.
  always_comb begin
    w_nxt_starve = r_starve;
    if (w_grant_blt || !blt_req) begin
      w_nxt_starve = 4'd0;
    end else if (w_grant_drw && (r_starve != 4'hF)) begin
      w_nxt_starve = r_starve + 4'd1;
    end else begin
      w_nxt_starve = r_starve;
    end
  end

  sram_io_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_io (
    .vgaClk      (vgaClk),
    .reset       (reset),
    .i_nxt_state (w_nxt_state),
    .i_grant_drw (w_grant_drw),
    .i_grant_blt (w_grant_blt),
    .i_cap_drw   (w_cap_drw),
    .i_cap_blt   (w_cap_blt),
    .i_drw_addr  (drw_addr),
    .i_blt_addr  (blt_addr),
    .i_blt_wdata (blt_wdata),
    .i_blt_be    (blt_be),
    .o_drw_grant (drw_grant),
    .o_blt_grant (blt_grant),
    .o_drw_rvalid(drw_rvalid),
    .o_blt_rvalid(blt_rvalid),
    .o_drw_rdata (drw_rdata),
    .o_blt_rdata (blt_rdata),
    .o_sram_addr (SRAM_ADDR),
    .io_sram_dq  (SRAM_DQ),
    .o_sram_ce_n (SRAM_CE_N),
    .o_sram_oe_n (SRAM_OE_N),
    .o_sram_we_n (SRAM_WE_N),
    .o_sram_ub_n (SRAM_UB_N),
    .o_sram_lb_n (SRAM_LB_N)
  );
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, hand-written corner sequences and a randomized
// run against a slot-level reference model with its own copy of the SRAM contents.
module tb_sram_arbiter;
  localparam int NRAND = 1500;
  localparam int MAXC  = NRAND + 16;
  localparam int SMAX  = 8;

  logic        vgaClk = 1'b0;
  logic        reset  = 1'b0;
  logic        drw_req = 1'b0, blt_req = 1'b0, blt_we = 1'b0;
  logic [19:0] drw_addr = 20'h0, blt_addr = 20'h0;
  logic [15:0] blt_wdata = 16'h0;
  logic [1:0]  blt_be = 2'b00;
  logic        drw_grant, drw_rvalid, blt_grant, blt_rvalid;
  logic [15:0] drw_rdata, blt_rdata;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int checks = 0;
  int failures = 0;

  always #5 vgaClk = ~vgaClk;

  sram_arbiter dut (
    .vgaClk(vgaClk), .reset(reset),
    .drw_req(drw_req), .drw_addr(drw_addr), .drw_grant(drw_grant),
    .drw_rdata(drw_rdata), .drw_rvalid(drw_rvalid),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_be(blt_be), .blt_grant(blt_grant), .blt_rdata(blt_rdata), .blt_rvalid(blt_rvalid),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  // SRAM model: 256 words, asynchronous read, write on the edge that ends a WE_N-low cycle.
  logic [15:0] mem [256];
  logic        mem_ready = 1'b0;
  logic        tb_probe = 1'b0;
  wire         mdrive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = mdrive ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;
  // A known pattern on an otherwise idle bus shows that the DUT is not driving it.
  assign SRAM_DQ = tb_probe ? 16'h5A5A : 16'hzzzz;

  function automatic logic [15:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 16) return 16'hA5A5;
    return {b ^ 8'h3C, ~b};
  endfunction

  always @(posedge vgaClk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vgaClk);
    #1;
  endtask

  task automatic clr_inputs();
    drw_req = 1'b0; blt_req = 1'b0; blt_we = 1'b0; blt_be = 2'b00;
  endtask

  task automatic check_ctrl(input string name, input logic [4:0] exp);
    check(name, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, exp);
  endtask

  task automatic check_bus_free(input string name);
    tb_probe = 1'b1;
    #1;
    check(name, SRAM_DQ, 16'h5A5A);
    tb_probe = 1'b0;
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_grants"}, {drw_grant, blt_grant}, 2'b00);
    check({name, "_rvalids"}, {drw_rvalid, blt_rvalid}, 2'b00);
    check_ctrl({name, "_ctrl"}, 5'b11111);
  endtask

  // Reference model: one slot at a time, next arbitration edge fixed by the access type.
  bit          exp_dg [MAXC], exp_bg [MAXC], exp_drv [MAXC], exp_brv [MAXC];
  logic [15:0] exp_drd [MAXC], exp_brd [MAXC];
  logic [15:0] ref_mem [256];
  int          mcyc, next_free, starve;

  task automatic model_step();
    bit gd, gb;
    logic [15:0] w;
    gd = 1'b0;
    gb = 1'b0;
    if (mcyc >= next_free) begin
      if (blt_req && (starve >= SMAX || !drw_req)) gb = 1'b1;
      else if (drw_req) gd = 1'b1;
    end
    if (gb || !blt_req) starve = 0;
    else if (gd && starve < 15) starve++;
    if (gd) begin
      exp_dg[mcyc] = 1'b1;
      exp_drv[mcyc+2] = 1'b1;
      exp_drd[mcyc+2] = ref_mem[drw_addr[7:0]];
      next_free = mcyc + 2;
    end
    if (gb) begin
      exp_bg[mcyc] = 1'b1;
      if (blt_we) begin
        w = ref_mem[blt_addr[7:0]];
        if (blt_be[1]) w[15:8] = blt_wdata[15:8];
        if (blt_be[0]) w[7:0]  = blt_wdata[7:0];
        ref_mem[blt_addr[7:0]] = w;
        next_free = mcyc + 3;
      end else begin
        exp_brv[mcyc+2] = 1'b1;
        exp_brd[mcyc+2] = ref_mem[blt_addr[7:0]];
        next_free = mcyc + 2;
      end
    end
    mcyc++;
  endtask

  typedef struct {
    logic       drw_req, blt_req, blt_we;
    logic [1:0] be;
    logic       exp_dg, exp_bg;
    logic [4:0] exp_ctrl;
  } vec_t;

  initial begin
    vec_t        vecs [8];
    int          gseq [$];
    int          gap, found, c;
    logic [15:0] hold_d, hold_b, lw;

    // Reset state
    clr_inputs();
    reset = 1'b0;
    repeat (3) step();
    check_quiet("reset");
    check("reset_rdata", {drw_rdata, blt_rdata}, 32'h0);
    check("reset_addr", SRAM_ADDR, 20'h0);
    check_bus_free("reset_dq_z");
    reset = 1'b1;
    step();

    // One-slot decisions from IDLE with a cleared starvation counter
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'b00100};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 5'b00100};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 5'b01000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 5'b01001};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 5'b01010};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 5'b01011};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'b00100};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'b11111};
    for (int i = 0; i < 8; i++) begin
      drw_req = vecs[i].drw_req; drw_addr = 20'h00031;
      blt_req = vecs[i].blt_req; blt_we = vecs[i].blt_we; blt_be = vecs[i].be;
      blt_addr = 20'h00032; blt_wdata = 16'h0F0F + 16'(i);
      step();
      check($sformatf("vec%0d_grants", i), {drw_grant, blt_grant}, {vecs[i].exp_dg, vecs[i].exp_bg});
      check_ctrl($sformatf("vec%0d_ctrl", i), vecs[i].exp_ctrl);
      if (vecs[i].exp_dg || vecs[i].exp_bg)
        check($sformatf("vec%0d_addr", i), SRAM_ADDR, vecs[i].exp_dg ? 20'h00031 : 20'h00032);
      clr_inputs();
      repeat (4) step();
    end

    // Drawer read latency: grant one cycle, rvalid three cycles after the sampling edge
    drw_req = 1'b1; drw_addr = 20'h00010;
    step();
    check("rd_grant", drw_grant, 1'b1);
    drw_req = 1'b0;
    step();
    check("rd_rvalid_early", drw_rvalid, 1'b0);
    step();
    check("rd_rvalid", drw_rvalid, 1'b1);
    check("rd_rdata", drw_rdata, 16'hA5A5);
    step();
    check("rd_rvalid_once", drw_rvalid, 1'b0);
    check("rd_rdata_hold", drw_rdata, 16'hA5A5);
    repeat (2) step();

    // Upper-byte write then TURN with the bus released
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 20'h00020; blt_wdata = 16'h1234; blt_be = 2'b10;
    step();
    check("wr_grant", blt_grant, 1'b1);
    check_ctrl("wr_ctrl", 5'b01001);
    check("wr_dq", SRAM_DQ, 16'h1234);
    clr_inputs();
    step();
    check_ctrl("turn_ctrl", 5'b11111);
    check_bus_free("turn_dq_z");
    step();
    lw = init_word(32);
    check("wr_mem", mem[32], {8'h12, lw[7:0]});

    // Both requesters held high: eight drawer slots then one blitter slot, repeating
    drw_req = 1'b1; drw_addr = 20'h00034;
    blt_req = 1'b1; blt_we = 1'b0; blt_addr = 20'h00035;
    for (int k = 0; k < 80 && gseq.size() < 18; k++) begin
      step();
      if (drw_grant) gseq.push_back(0);
      if (blt_grant) gseq.push_back(1);
    end
    check("starve_count", gseq.size(), 18);
    for (int i = 0; i < gseq.size() && i < 18; i++)
      check($sformatf("starve_slot%0d", i), gseq[i], (i % 9 == 8) ? 1 : 0);
    clr_inputs();
    repeat (4) step();

    // Write immediately followed by a read: bus idles through TURN and IDLE
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 20'h00036; blt_wdata = 16'hBEEF; blt_be = 2'b11;
    step();
    check("w2r_we_low", SRAM_WE_N, 1'b0);
    clr_inputs();
    drw_req = 1'b1; drw_addr = 20'h00037;
    gap = 0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (!SRAM_OE_N) found = 1;
      else if (SRAM_CE_N && SRAM_WE_N) gap++;
    end
    check("w2r_oe_seen", found, 1);
    check("w2r_gap", gap, 2);
    check("w2r_grant", drw_grant, 1'b1);
    clr_inputs();
    repeat (4) step();

    // Reset during WR, and during RD_CAP
    blt_req = 1'b1; blt_we = 1'b1; blt_addr = 20'h00030; blt_wdata = 16'hC3C3; blt_be = 2'b11;
    step();
    check("rstwr_we_low", SRAM_WE_N, 1'b0);
    clr_inputs();
    reset = 1'b0;
    step();
    check_quiet("rstwr");
    check_bus_free("rstwr_dq_z");
    reset = 1'b1;
    repeat (3) begin
      step();
      check_quiet("rstwr_after");
    end
    drw_req = 1'b1; drw_addr = 20'h00010;
    step();
    check("rstrd_grant", drw_grant, 1'b1);
    drw_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rstrd_rvalid", drw_rvalid, 1'b0);
    check("rstrd_rdata", drw_rdata, 16'h0);
    reset = 1'b1;
    step();
    check("rstrd_rvalid_late", drw_rvalid, 1'b0);

    // Idle for twenty cycles
    for (int k = 0; k < 20; k++) begin
      step();
      check_quiet($sformatf("idle%0d", k));
    end

    // Randomized traffic against the reference model (addresses above the hand-test area)
    reset = 1'b0;
    clr_inputs();
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    mcyc = 0; next_free = 0; starve = 0;
    hold_d = 16'h0; hold_b = 16'h0;
    for (int n = 0; n < NRAND; n++) begin
      model_step();
      step();
      c = mcyc - 1;
      check("rnd_drw_grant", drw_grant, exp_dg[c]);
      check("rnd_blt_grant", blt_grant, exp_bg[c]);
      check("rnd_drw_rvalid", drw_rvalid, exp_drv[c]);
      check("rnd_blt_rvalid", blt_rvalid, exp_brv[c]);
      if (exp_drv[c]) hold_d = exp_drd[c];
      if (exp_brv[c]) hold_b = exp_brd[c];
      check("rnd_drw_rdata", drw_rdata, hold_d);
      check("rnd_blt_rdata", blt_rdata, hold_b);
      if (exp_dg[c]) drw_req = 1'b0;
      if (exp_bg[c]) blt_req = 1'b0;
      if (!drw_req && $urandom_range(0, 99) < 45) begin
        drw_req = 1'b1;
        drw_addr = {12'h000, 8'($urandom_range(64, 255))};
      end
      if (!blt_req && $urandom_range(0, 99) < 35) begin
        blt_req = 1'b1;
        blt_we = 1'($urandom_range(0, 1));
        blt_addr = {12'h000, 8'($urandom_range(64, 255))};
        blt_wdata = 16'($urandom);
        blt_be = 2'($urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20: SRAM word-address width.
REQ-002 Parameter DATA_W, default 16: SRAM data width.
REQ-003 Parameter STARVE_MAX, default 8: maximum consecutive drawer grants while blt_req is pending.
REQ-004 Clock and reset: clock vgaClk; reset reset, synchronous, active-low.
REQ-005 vgaClk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low.
REQ-007 drw_req  in  1  drawer read request, held until drw_grant.
REQ-008 drw_addr  in  ADDR_W  drawer read address.
REQ-009 drw_grant  out  1  one-cycle pulse: drawer request accepted.
REQ-010 drw_rdata / drw_rvalid  out  DATA_W / 1  read data and one-cycle valid strobe.
REQ-011 blt_req, blt_we  in  1, 1  blitter request, held until blt_grant; blt_we selects write (1) or read (0).
REQ-012 blt_addr, blt_wdata, blt_be  in  ADDR_W, DATA_W, 2  blitter address, write data, byte enables ([1]=upper, [0]=lower).
REQ-013 blt_grant, blt_rdata, blt_rvalid  out  1, DATA_W, 1  blitter grant pulse, read data, valid strobe.
REQ-014 SRAM_ADDR  out  ADDR_W; SRAM_DQ  inout  DATA_W; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each, all active-low and registered.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_CAP, WR, TURN.
REQ-016 Transitions: IDLE or RD_CAP with a request goes to RD_ADDR or WR per arbitration; RD_ADDR goes to RD_CAP; WR goes to TURN; TURN goes to IDLE; RD_CAP with no request goes to IDLE.
REQ-017 Arbitration is evaluated only in IDLE and RD_CAP; the drawer has strict priority, except under REQ-018.
REQ-018 A 4-bit counter tracks consecutive drawer grants while blt_req=1; at STARVE_MAX the next slot goes to the blitter; the counter clears on any blitter grant or when blt_req=0.
REQ-019 The grant pulse is asserted in the first cycle of RD_ADDR or WR, and the address and data are latched at that edge.
REQ-020 RD_ADDR: CE_N=0, OE_N=0, WE_N=1, UB_N=LB_N=0, DQ tri-stated.
REQ-021 RD_CAP: SRAM_DQ is sampled at the end of the cycle; the selected rvalid is asserted the next cycle with rdata.
REQ-022 Read latency: request sampled at edge N, grant in cycle N+1, rvalid in cycle N+3.
REQ-023 Back-to-back reads issue every 2 cycles.
REQ-024 WR: CE_N=0, WE_N=0, OE_N=1; UB_N=~blt_be[1], LB_N=~blt_be[0]; DQ driven with blt_wdata for this cycle only.
REQ-025 TURN: all SRAM controls inactive and DQ tri-stated; a read never directly follows a write.
REQ-026 blt_be=2'b00 still consumes a WR slot, with both UB_N and LB_N high.
REQ-027 Simultaneous drw_req and blt_req with counter < STARVE_MAX: drawer wins; blitter waits.
REQ-028 rdata holds its last value between rvalid strobes; only one grant or rvalid is asserted per cycle.

Reset
REQ-029 Reset state: state=IDLE, counter=0, grants=0, rvalids=0, rdata=0, SRAM_ADDR=0.
REQ-030 Reset state of SRAM controls: CE_N=OE_N=WE_N=UB_N=LB_N=1, DQ tri-stated.
REQ-031 Reset asserted mid-access (including WR) forces the reset state on the next edge; no rvalid is issued for an aborted access.

Structure
REQ-032 Shared package metroid_pkg holds the state enum type, ADDR_W/DATA_W defaults and the STARVE_MAX default.
REQ-033 One sub-module, sram_io_reg, holds the output registers and the DQ tri-state driver; arbitration and the FSM stay in sram_arbiter.

Verification
REQ-034 drw_req with drw_addr=20'h00010, SRAM model returns 16'hA5A5 -> drw_grant in cycle N+1, drw_rvalid with drw_rdata=16'hA5A5 in cycle N+3.
REQ-035 blt write to addr=20'h00020, data=16'h1234, be=2'b10 -> one WR cycle with WE_N=0, UB_N=0, LB_N=1, then TURN with DQ at Z; model upper byte is 8'h12.
REQ-036 drw_req and blt_req held high continuously -> 8 drawer grants, 1 blitter grant, pattern repeats.
REQ-037 Blitter write immediately followed by drawer read -> exactly one TURN cycle between WE_N rising and OE_N falling.
REQ-038 reset=0 during WR -> next cycle all controls high, DQ at Z, state IDLE, no rvalid.
REQ-039 No requests for 20 cycles -> state remains IDLE, all controls high, no grant or rvalid pulses.
